order_encoder: RTL
==================

Name: order_encoder

Overview:
- Transmit-side counterpart of the feed decoder's Avalon-ST packet input.
- Accepts one decoded order per handshake from the strategy's order path.
- Serializes each order into a fixed-format, big-endian, 64-bit Avalon-ST packet for the MAC/TX path.
- Stamps each packet with a wrapping 16-bit sequence number and keeps a saturating sent-packet counter.

Parameters:
- C_PKT_DATA_WIDTH, 64, output data width; only 64 is supported, and elaboration errors on any other value.
- C_PKT_EMPTY_WIDTH, 3, width of out_empty; equals $clog2(C_PKT_DATA_WIDTH/8).
- MSG_TYPE, 8'h4F, message-type byte placed in byte 0 of every packet.
- SEQ_INIT, 16'h0000, sequence number loaded at reset.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  synchronous active-low reset.
- ord_valid  in  1  order valid.
- ord_ready  out  1  order accepted when ord_valid and ord_ready are both high.
- ord_side  in  1  0 = buy, 1 = sell.
- ord_ref  in  32  order reference.
- ord_stock  in  64  8-character ASCII symbol.
- ord_price  in  32  price.
- ord_volume  in  32  volume.
- out_ready  in  1  Avalon-ST sink ready (readyLatency 0).
- out_valid  out  1  beat valid.
- out_startofpacket  out  1  first beat of packet.
- out_endofpacket  out  1  last beat of packet.
- out_data  out  64  beat data; byte 0 is in [63:56].
- out_empty  out  3  unused bytes on the EOP beat.
- out_error  out  1  tied to 0.
- pkt_cnt  out  32  packets fully sent, saturating.

Behaviour:
- Reset (synchronous, reset_n low at a clk edge):
  - All outputs go to 0, except ord_ready, which goes to 1.
  - State goes to IDLE; the sequence register loads SEQ_INIT; pkt_cnt goes to 0.
  - A packet in flight is dropped with no EOP, and that is accepted behaviour.
- States: IDLE, BEAT0, BEAT1, BEAT2, BEAT3. BEAT3 exists only with the optional feature.
- ord_ready is registered, and is 1 only in IDLE.
- Order accept (IDLE with ord_valid high):
  - All order fields are captured into holding registers.
  - The next state is BEAT0, and out_valid rises on the following cycle; acceptance-to-first-beat latency is 1 cycle.
- Beat contents, big-endian:
  - BEAT0 = {MSG_TYPE, side byte, seq[15:0], ord_ref}, with out_startofpacket = 1. Side byte is 8'h42 ('B') for buy and 8'h53 ('S') for sell.
  - BEAT1 = ord_stock.
  - BEAT2 = {ord_price, ord_volume}.
- Beat advance: a state advances only on a cycle where out_valid and out_ready are both high.
  - While out_ready is low, out_valid, out_data, out_startofpacket, out_endofpacket and out_empty hold stable.
  - out_valid never drops mid-packet.
- Final beat accepted:
  - pkt_cnt increments, saturating at 32'hFFFF_FFFF.
  - The sequence register increments modulo 2^16, so 16'hFFFF wraps to 16'h0000.
  - State returns to IDLE.
- Throughput: at least one idle cycle between packets, because ord_ready is only high in IDLE.
  - Minimum packet period is 4 cycles without the optional feature and 5 cycles with it.
- Captured order fields do not change while a packet is in flight. Changes on the ord_* inputs are ignored until the next accept.
- out_empty is 0 on every beat except a checksum EOP beat.
- out_error is always 0.

Optional Feature:
- Macro: ORDER_ENC_CKSUM_EN.
- Defined:
  - BEAT2 has out_endofpacket = 0.
  - A fourth beat, BEAT3, is sent: {cksum[15:0], 48'h0}, with out_endofpacket = 1 and out_empty = 3'd6.
  - cksum is the modulo-2^16 sum of the twelve 16-bit big-endian words of BEAT0 through BEAT2.
  - cksum is computed incrementally as beats are accepted, or fully at capture time; either is acceptable, as long as the value is ready when BEAT3 is presented.
- Undefined: BEAT2 carries out_endofpacket = 1 with out_empty = 0. No checksum logic is present.

Test Plan:
- Single order, no backpressure: side = 0, ref = 0, stock = 0, price = 0, volume = 0, out_ready held 1 → beats are 64'h4F42_0000_0000_0000 (SOP), 0, 0 (EOP, empty 0); pkt_cnt = 1; the next packet carries seq 1.
  - With ORDER_ENC_CKSUM_EN, a fourth beat 64'h4F42_0000_0000_0000 follows with EOP and empty = 6.
- Sell order: side = 1, ref = 32'h0000_0102, stock = "AAPL    ", price = 32'd15000, volume = 32'd100 → beat0 = 64'h4F53_0000_0000_0102; beat1 = 64'h4141_504C_2020_2020; beat2 = 64'h0000_3A98_0000_0064.
- Backpressure: toggle out_ready 1-0-0-1-0-1 during a packet → each beat is held stable while ready is low; no beat is duplicated or lost; exactly 3 (or 4) beats are accepted.
- Sequence wrap: SEQ_INIT = 16'hFFFE, send 3 orders → seq fields are FFFE, FFFF, 0000.
- Reset mid-packet: assert reset_n low while BEAT1 is presented → next cycle out_valid = 0, ord_ready = 1, pkt_cnt = 0; the next order starts with SOP and seq = SEQ_INIT.
- Back-to-back: ord_valid held high with 4 distinct orders → 4 complete packets in order, one IDLE cycle between packets, pkt_cnt = 4.

Source files
------------

// File: rtl/order_encoder.sv
// Serializes one accepted order into a big-endian 64-bit Avalon-ST packet with a sequence stamp.
// Optional macro ORDER_ENC_CKSUM_EN appends a fourth beat carrying a 16-bit word checksum.
module order_encoder #(
  parameter int          C_PKT_DATA_WIDTH  = 64,
  parameter int          C_PKT_EMPTY_WIDTH = 3,
  parameter logic [7:0]  MSG_TYPE          = 8'h4F,
  parameter logic [15:0] SEQ_INIT          = 16'h0000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ord_valid,
  output logic                         ord_ready,
  input  logic                         ord_side,
  input  logic [31:0]                  ord_ref,
  input  logic [63:0]                  ord_stock,
  input  logic [31:0]                  ord_price,
  input  logic [31:0]                  ord_volume,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic                         out_startofpacket,
  output logic                         out_endofpacket,
  output logic [C_PKT_DATA_WIDTH-1:0]  out_data,
  output logic [C_PKT_EMPTY_WIDTH-1:0] out_empty,
  output logic                         out_error,
  output logic [31:0]                  pkt_cnt
);

  if (C_PKT_DATA_WIDTH != 64) begin : g_width_check
    $error("order_encoder supports only C_PKT_DATA_WIDTH = 64");
  end

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; once out_valid rises, it and the beat fields hold until taken.
`ifdef ORDER_ENC_CKSUM_EN
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, BEAT3} state_t;
`else
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2} state_t;
`endif

  state_t       state_q, state_d;
  logic         ord_ready_q;
  logic         side_q;
  logic [31:0]  ref_q;
  logic [63:0]  stock_q;
  logic [31:0]  price_q;
  logic [31:0]  volume_q;
  logic [15:0]  seq_q;
  logic [31:0]  pkt_cnt_q;
  logic         accept;
  logic         last_beat_done;
  logic [7:0]   side_byte;
  logic [63:0]  beat_data;

  assign accept    = (state_q == IDLE) && ord_valid;
  assign side_byte = side_q ? 8'h53 : 8'h42;

`ifdef ORDER_ENC_CKSUM_EN
  // Derived from the holding registers, which are frozen for the whole packet.
  logic [15:0] cksum;
  assign cksum = {MSG_TYPE, side_byte} + seq_q + ref_q[31:16] + ref_q[15:0]
               + stock_q[63:48] + stock_q[47:32] + stock_q[31:16] + stock_q[15:0]
               + price_q[31:16] + price_q[15:0] + volume_q[31:16] + volume_q[15:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ord_ready_q <= 1'b1;
      side_q      <= 1'b0;
      ref_q       <= '0;
      stock_q     <= '0;
      price_q     <= '0;
      volume_q    <= '0;
      seq_q       <= SEQ_INIT;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ord_ready_q <= (state_d == IDLE);
      if (accept) begin
        side_q   <= ord_side;
        ref_q    <= ord_ref;
        stock_q  <= ord_stock;
        price_q  <= ord_price;
        volume_q <= ord_volume;
      end
      if (last_beat_done) begin
        seq_q <= seq_q + 16'd1;
        if (pkt_cnt_q != 32'hFFFF_FFFF) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    out_valid         = 1'b0;
    out_startofpacket = 1'b0;
    out_endofpacket   = 1'b0;
    out_empty         = '0;
    beat_data         = '0;
    last_beat_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ord_valid) state_d = BEAT0;
      end
      BEAT0: begin
        out_valid         = 1'b1;
        out_startofpacket = 1'b1;
        beat_data         = {MSG_TYPE, side_byte, seq_q, ref_q};
        if (out_ready) state_d = BEAT1;
      end
      BEAT1: begin
        out_valid = 1'b1;
        beat_data = stock_q;
        if (out_ready) state_d = BEAT2;
      end
      BEAT2: begin
        out_valid = 1'b1;
        beat_data = {price_q, volume_q};
`ifdef ORDER_ENC_CKSUM_EN
        if (out_ready) state_d = BEAT3;
`else
        out_endofpacket = 1'b1;
        if (out_ready) begin
          state_d        = IDLE;
          last_beat_done = 1'b1;
        end
`endif
      end
`ifdef ORDER_ENC_CKSUM_EN
      BEAT3: begin
        out_valid       = 1'b1;
        out_endofpacket = 1'b1;
        out_empty       = C_PKT_EMPTY_WIDTH'(6);
        beat_data       = {cksum, 48'h0};
        if (out_ready) begin
          state_d        = IDLE;
          last_beat_done = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ord_ready = ord_ready_q;
  assign out_data  = beat_data;
  assign out_error = 1'b0;
  assign pkt_cnt   = pkt_cnt_q;

endmodule
